// File: rtl/vector_mem_sequencer_if.sv
// Single-word data memory port between the M-stage vector sequencer (master)
// and the data memory (slave).
interface vector_mem_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memReadEnable;
  logic                  memWriteEnable;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic                  memReady;
  logic [DATA_WIDTH-1:0] memReadData;

  modport master (
    output memAddr, memReadEnable, memWriteEnable, memWriteData,
    input  memReady, memReadData
  );

  modport slave (
    input  memAddr, memReadEnable, memWriteEnable, memWriteData,
    output memReady, memReadData
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// M-stage sequencer: splits one vector (or scalar) load/store into single-word
// memory accesses, freezes the pipeline meanwhile, and assembles load lanes.
module vector_mem_sequencer #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          startM,
  input  logic                          isStoreM,
  input  logic                          isVectorM,
  input  logic [ADDR_WIDTH-1:0]         baseAddrM,
  input  logic [LANES*DATA_WIDTH-1:0]   storeDataM,
  output logic                          stallM,
  output logic [LANES*DATA_WIDTH-1:0]   loadDataW,
  output logic                          loadValidW,
  output logic                          doneM,
  vector_mem_sequencer_if.master        mem
);

  localparam int LW    = LANES * DATA_WIDTH;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        last_q;
  logic                    isStore_q;
  logic [LW-1:0]           storeData_q;
  logic [LW-1:0]           asm_q;
  logic [LW-1:0]           asm_d;
  logic                    cap_q;
  logic [CNT_W-1:0]        capLane_q;
  logic [LW-1:0]           loadData_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    re_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wd_q;

  function automatic logic [DATA_WIDTH-1:0] lane_sel(input logic [LW-1:0] v,
                                                     input logic [CNT_W-1:0] idx);
    return v[idx*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Read data arrives one cycle after acceptance; merge it into its lane here so
  // the DRAIN->DONE edge can publish the final lane together with the rest.
  always_comb begin
    asm_d = asm_q;
    if (cap_q) asm_d[capLane_q*DATA_WIDTH +: DATA_WIDTH] = mem.memReadData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      count_q     <= '0;
      last_q      <= '0;
      isStore_q   <= 1'b0;
      storeData_q <= '0;
      asm_q       <= '0;
      cap_q       <= 1'b0;
      capLane_q   <= '0;
      loadData_q  <= '0;
      addr_q      <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      wd_q        <= '0;
    end else begin
      asm_q <= asm_d;
      cap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startM) begin
            count_q     <= '0;
            last_q      <= isVectorM ? CNT_W'(LANES - 1) : '0;
            isStore_q   <= isStoreM;
            storeData_q <= storeDataM;
            asm_q       <= '0;
            addr_q      <= baseAddrM;
            re_q        <= !isStoreM;
            we_q        <= isStoreM;
            wd_q        <= isStoreM ? storeDataM[DATA_WIDTH-1:0] : '0;
            state_q     <= XFER;
          end
        end
        XFER: begin
          cap_q     <= re_q && mem.memReady;
          capLane_q <= count_q;
          if (mem.memReady) begin
            if (count_q != last_q) begin
              count_q <= count_q + CNT_W'(1);
              addr_q  <= addr_q + ADDR_WIDTH'(1);
              wd_q    <= isStore_q ? lane_sel(storeData_q, count_q + CNT_W'(1)) : '0;
            end else begin
              re_q    <= 1'b0;
              we_q    <= 1'b0;
              addr_q  <= '0;
              wd_q    <= '0;
              state_q <= isStore_q ? DONE : DRAIN;
            end
          end
        end
        DRAIN: begin
          loadData_q <= asm_d;
          state_q    <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The request cycle itself must already freeze upstream, hence startM in IDLE.
  assign stallM             = (state_q == IDLE) ? startM : (state_q != DONE);
  assign doneM              = (state_q == DONE);
  assign loadValidW         = (state_q == DONE) && !isStore_q;
  assign loadDataW          = loadData_q;
  assign mem.memAddr        = addr_q;
  assign mem.memReadEnable  = re_q;
  assign mem.memWriteEnable = we_q;
  assign mem.memWriteData   = wd_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer with a behavioural word memory.
module tb_vector_mem_sequencer;
  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int LW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          startM = 1'b0;
  logic          isStoreM = 1'b0;
  logic          isVectorM = 1'b0;
  logic [AW-1:0] baseAddrM = '0;
  logic [LW-1:0] storeDataM = '0;
  logic          stallM;
  logic [LW-1:0] loadDataW;
  logic          loadValidW;
  logic          doneM;

  vector_mem_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

  vector_mem_sequencer #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .startM    (startM),
    .isStoreM  (isStoreM),
    .isVectorM (isVectorM),
    .baseAddrM (baseAddrM),
    .storeDataM(storeDataM),
    .stallM    (stallM),
    .loadDataW (loadDataW),
    .loadValidW(loadValidW),
    .doneM     (doneM),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem_model [0:65535];
  logic [AW+DW-1:0] wq[$];
  logic [LW-1:0]    lq[$];

  int stall_cnt = 0, acc_cnt = 0, watch_cnt = 0, done_cnt = 0, done_cyc = 0, lv_cnt = 0;
  logic [AW-1:0] watch_addr = 16'hDEAD;
  bit            rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rstN) begin
      if (stallM) stall_cnt++;
      if (mif.memReadEnable && mif.memWriteEnable) check("en_excl", 1, 0);
      if (mif.memReadEnable && mif.memAddr == watch_addr) watch_cnt++;
      if (mif.memReady && mif.memWriteEnable) begin
        acc_cnt++;
        if (wq.size() == 0) check("unexp_wr", 1, 0);
        else begin
          logic [AW+DW-1:0] e;
          e = wq.pop_front();
          check("wr_addr", mif.memAddr, e[AW+DW-1:DW]);
          check("wr_data", mif.memWriteData, e[DW-1:0]);
        end
        mem_model[mif.memAddr] = mif.memWriteData;
      end
      if (mif.memReady && mif.memReadEnable) begin
        acc_cnt++;
        rd_pend = 1'b1;
        rd_addr = mif.memAddr;
      end else rd_pend = 1'b0;
      if (loadValidW) begin
        lv_cnt++;
        check("valid_done", doneM, 1);
        if (lq.size() == 0) check("unexp_load", 1, 0);
        else check("load_data", loadDataW, lq.pop_front());
      end
      if (doneM) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else rd_pend = 1'b0;
  end

  // Memory read data is valid only for the cycle after acceptance.
  always @(posedge clk) begin
    #1;
    mif.memReadData = rd_pend ? mem_model[rd_addr] : 8'hEE;
  end

  task automatic start_op(input bit st, input bit vec, input logic [AW-1:0] base,
                          input logic [LW-1:0] sd, output int t);
    @(posedge clk);
    #1;
    stall_cnt = 0;
    acc_cnt   = 0;
    watch_cnt = 0;
    t         = cyc;
    startM    = 1'b1;
    isStoreM  = st;
    isVectorM = vec;
    baseAddrM = base;
    storeDataM = sd;
    if (st) begin
      for (int i = 0; i < (vec ? LANES : 1); i++) begin
        logic [AW-1:0] a;
        a = base + AW'(i);
        wq.push_back({a, sd[i*DW +: DW]});
      end
    end
    @(negedge clk);
    check("stall_req", stallM, 1);
    @(posedge clk);
    #1;
    startM = 1'b0;
  endtask

  task automatic wait_done(input int t, input int d0, input int lat, input string tag);
    int i;
    i = 0;
    while (done_cnt == d0 && i < 40) begin
      @(posedge clk);
      i++;
    end
    if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
    else check(tag, done_cyc - t, lat);
  endtask

  initial begin
    int t, d0, l0;
    mem_model[16'h0100] = 8'hA0;
    mem_model[16'h0101] = 8'hA1;
    mem_model[16'h0102] = 8'hA2;
    mem_model[16'h0103] = 8'hA3;
    mem_model[16'h0005] = 8'h7E;
    mif.memReady    = 1'b1;
    mif.memReadData = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stallM, 0);
    check("rst_re", mif.memReadEnable, 0);
    check("rst_we", mif.memWriteEnable, 0);
    check("rst_addr", mif.memAddr, 0);
    check("rst_ldata", loadDataW, 0);
    check("rst_done", {loadValidW, doneM}, 0);
    @(negedge clk);
    rstN = 1'b1;

    // Vector store
    d0 = done_cnt;
    start_op(1'b1, 1'b1, 16'h0010, 32'h44332211, t);
    wait_done(t, d0, LANES + 1, "st_lat");
    check("st_stall", stall_cnt, LANES + 1);
    check("st_acc", acc_cnt, LANES);
    check("st_wq", wq.size(), 0);
    @(negedge clk);
    check("done_pulse", doneM, 0);

    // Vector load
    d0 = done_cnt;
    lq.push_back(32'hA3A2A1A0);
    start_op(1'b0, 1'b1, 16'h0100, '0, t);
    wait_done(t, d0, LANES + 2, "vld_lat");
    check("vld_stall", stall_cnt, LANES + 2);
    check("vld_lq", lq.size(), 0);

    // Scalar load
    d0 = done_cnt;
    lq.push_back(32'h0000007E);
    start_op(1'b0, 1'b0, 16'h0005, '0, t);
    wait_done(t, d0, 3, "sld_lat");
    check("sld_acc", acc_cnt, 1);
    check("sld_stall", stall_cnt, 3);
    check("sld_lq", lq.size(), 0);

    // Vector load with memReady low for two cycles at lane 1
    d0 = done_cnt;
    watch_addr = 16'h0101;
    lq.push_back(32'hA3A2A1A0);
    start_op(1'b0, 1'b1, 16'h0100, '0, t);
    @(posedge clk);
    #1;
    mif.memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mif.memReady = 1'b1;
    wait_done(t, d0, LANES + 4, "wait_lat");
    check("wait_hold", watch_cnt, 3);
    check("wait_stall", stall_cnt, LANES + 4);
    check("wait_lq", lq.size(), 0);
    watch_addr = 16'hDEAD;

    // Address wrap on a vector store; earlier load result must be held
    d0 = done_cnt;
    start_op(1'b1, 1'b1, 16'hFFFE, 32'h55667788, t);
    wait_done(t, d0, LANES + 1, "wrap_lat");
    check("wrap_wq", wq.size(), 0);
    check("ld_hold", loadDataW, 32'hA3A2A1A0);

    // Asynchronous reset during lane 2 of a load
    d0 = done_cnt;
    l0 = lv_cnt;
    start_op(1'b0, 1'b1, 16'h0100, '0, t);
    repeat (2) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("mrst_stall", stallM, 0);
    check("mrst_re", mif.memReadEnable, 0);
    check("mrst_addr", mif.memAddr, 0);
    check("mrst_ldata", loadDataW, 0);
    check("mrst_done", {loadValidW, doneM}, 0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    repeat (8) @(posedge clk);
    check("mrst_no_valid", lv_cnt, l0);
    check("mrst_no_done", done_cnt, d0);

    // New store after reset; startM during XFER must be ignored
    d0 = done_cnt;
    start_op(1'b1, 1'b1, 16'h0200, 32'h04030201, t);
    @(posedge clk);
    #1;
    startM    = 1'b1;
    isStoreM  = 1'b0;
    baseAddrM = 16'h0300;
    @(posedge clk);
    #1;
    startM = 1'b0;
    wait_done(t, d0, LANES + 1, "ign_lat");
    repeat (10) @(posedge clk);
    check("ign_acc", acc_cnt, LANES);
    check("ign_done_cnt", done_cnt, d0 + 1);
    check("ign_no_valid", lv_cnt, l0);
    check("ign_wq", wq.size(), 0);
    check("mem_wrap0", mem_model[16'h0000], 8'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Sits in the M stage, between the pipeline register carrying writeToMemoryEnable/resultSelector controls and the single-word data memory port.
- Serializes one vector load or store into LANES single-word memory accesses. Scalar accesses take the same path as a one-word transfer.
- Holds stallM high while busy so the upstream stages freeze.
- Assembles load lanes into one full-width word for the WB stage.

Parameters:
- LANES, 4, vector lanes per access (>=1).
- DATA_WIDTH, 8, bits per lane / memory word.
- ADDR_WIDTH, 16, memory word-address width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rstN  in  1  asynchronous, active-low reset.
- startM  in  1  access request from M stage; sampled only in IDLE.
- isStoreM  in  1  1=store, 0=load; latched at start.
- isVectorM  in  1  1=LANES-word access, 0=single word (lane 0 only); latched at start.
- baseAddrM  in  ADDR_WIDTH  word address of lane 0; latched at start.
- storeDataM  in  LANES*DATA_WIDTH  store data, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]; latched at start.
- stallM  out  1  pipeline freeze.
- memAddr  out  ADDR_WIDTH  memory address.
- memReadEnable  out  1  read request.
- memWriteEnable  out  1  write request.
- memWriteData  out  DATA_WIDTH  write data.
- memReady  in  1  memory accepts the current request on this edge.
- memReadData  in  DATA_WIDTH  read data, valid exactly one cycle after an accepted read.
- loadDataW  out  LANES*DATA_WIDTH  assembled load result; held until the next load completes.
- loadValidW  out  1  one-cycle pulse: loadDataW updated.
- doneM  out  1  one-cycle pulse: access complete (load or store).

Behaviour:
- Reset (async, rstN=0):
  - state=IDLE, lane counter=0, latched operands=0.
  - All outputs 0, including loadDataW.
  - Reset mid-transfer abandons it; no partial loadValidW/doneM.
- FSM states: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - stallM = startM (combinational), so the request cycle is already frozen.
  - On startM: latch operands, count=0, last = isVectorM ? LANES-1 : 0, then go to XFER.
- XFER:
  - stallM=1. memAddr = base + count, modulo 2^ADDR_WIDTH (wraps, no error).
  - Store: memWriteEnable=1, memWriteData = lane[count].
  - Load: memReadEnable=1.
  - Request and address stay stable until memReady=1.
  - On an edge with memReady=1:
    - count < last: count+1, stay in XFER.
    - count == last: go to DRAIN if load, DONE if store.
- Load capture:
  - Data of the read accepted at lane k is written into assembly lane k on the following edge, regardless of the state in that cycle.
  - Scalar load: lanes 1..LANES-1 are zero.
  - The assembly buffer is separate from loadDataW and is cleared at start.
- DRAIN: stallM=1, no memory request, captures the final lane; next state DONE.
- DONE:
  - stallM=0, doneM=1.
  - Load: loadDataW <= assembly buffer on the DONE-entry edge; loadValidW=1 during DONE.
  - Next state IDLE unconditionally; startM is ignored in DONE.
- startM while not in IDLE is ignored; no queuing.
- Latency with memReady held at 1, start at cycle T:
  - Store: XFER T+1..T+LANES, DONE at T+LANES+1.
  - Load: DRAIN at T+LANES+1, DONE at T+LANES+2.
- memReadEnable and memWriteEnable are never both 1. Both are 0 outside XFER.

Test Plan:
- Vector store, LANES=4, base=0x0010, storeData lanes {0x11,0x22,0x33,0x44}, memReady=1 -> writes 0x11@0x10, 0x22@0x11, 0x33@0x12, 0x44@0x13 on T+1..T+4; doneM at T+5; stallM=1 from T to T+4.
- Vector load, base=0x0100, memory holds {0xA0,0xA1,0xA2,0xA3} -> loadDataW={0xA3,0xA2,0xA1,0xA0} (lane3..lane0) with loadValidW and doneM at T+6.
- Scalar load from 0x0005 holding 0x7E -> one read; loadDataW=0x0000007E at T+3.
- Vector load with memReady low for 2 cycles at lane 1 -> memAddr=base+1 held 3 cycles; result correct; DONE delayed exactly 2 cycles.
- Wrap: base=0xFFFE vector store -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rstN pulsed low during lane 2 of a load -> outputs 0 immediately, loadValidW never pulses. A new startM after reset completes normally. A startM asserted during XFER is ignored (exactly 4 accesses).
